// File: rtl/seq_mul_unit.sv
// Sequential shift-and-add unsigned multiplier: one partial-product step per clock,
// SIZE steps per operation, product held until the next accepted start.
module seq_mul_unit #(
    parameter int SIZE = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [SIZE-1:0]     a,
    input  logic [SIZE-1:0]     b,
    output logic                busy,
    output logic                done,
    output logic [2*SIZE-1:0]   product
);

    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic [CW-1:0]       cnt;
    logic [SIZE-1:0]     reg_a;
    logic [2*SIZE-1:0]   p;
    logic [SIZE:0]       sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                // cnt==1 means this edge performs the final step
                if (cnt == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Carry-out lands in the top bit of P, so no product bit is ever lost.
    assign sum = {1'b0, p[2*SIZE-1:SIZE]} + {1'b0, reg_a};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            reg_a <= '0;
            p     <= '0;
        end else if (accept) begin
            cnt   <= CW'(SIZE);
            reg_a <= a;
            p     <= {{SIZE{1'b0}}, b};
        end else if (state == RUN) begin
            cnt <= cnt - CW'(1);
            if (p[0]) begin
                p <= {sum, p[SIZE-1:1]};
            end else begin
                p <= {1'b0, p[2*SIZE-1:1]};
            end
        end
    end

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign product = p;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Self-checking bench for seq_mul_unit: directed scenarios plus randomized operands
// at SIZE=32 and SIZE=8, checked against plain widened multiplication.
module tb_seq_mul_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;

    int tests_run;
    int fails;

    seq_mul_unit #(.SIZE(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    seq_mul_unit #(.SIZE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(product8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive at a negedge; returns at the negedge after the accepting edge (edge 1).
    task automatic launch32(input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic launch8(input logic [7:0] va, input logic [7:0] vb);
        @(negedge clk);
        a8 = va; b8 = vb; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Counts edges since acceptance (inclusive) until done is seen, bounded.
    task automatic wait_done32(output int edges, output int busy_cycles);
        edges = 1;
        busy_cycles = busy ? 1 : 0;
        while (!done && edges < 100) begin
            @(negedge clk);
            edges++;
            if (busy) busy_cycles++;
        end
    endtask

    task automatic wait_done8(output int edges);
        edges = 1;
        while (!done8 && edges < 40) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; start8 = 1'b0;
        a = '0; b = '0; a8 = '0; b8 = '0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL reset_flags busy=%b done=%b expected 0 0", busy, done);
        end
        tests_run++;
        if (product !== 64'd0) begin
            fails++; $display("FAIL reset_product got %h expected 0", product);
        end
        tests_run++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== 16'd0) begin
            fails++; $display("FAIL reset_size8 busy=%b done=%b product=%h expected 0", busy8, done8, product8);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int edges, bc;
        launch32(32'd3, 32'd5);
        wait_done32(edges, bc);
        tests_run++;
        if (edges !== 33) begin
            fails++; $display("FAIL basic_latency got %0d edges expected 33", edges);
        end
        tests_run++;
        if (bc !== 32) begin
            fails++; $display("FAIL basic_busy_cycles got %0d expected 32", bc);
        end
        tests_run++;
        if (product !== 64'd15 || done !== 1'b1) begin
            fails++; $display("FAIL basic_product got %0d done=%b expected 15 done=1", product, done);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || product !== 64'd15) begin
            fails++; $display("FAIL basic_after got done=%b busy=%b product=%0d expected 0 0 15", done, busy, product);
        end
    endtask

    task automatic test_extremes;
        logic [31:0] xa [3];
        logic [31:0] xb [3];
        logic [63:0] xp [3];
        int edges, bc;
        xa[0] = 32'hFFFFFFFF; xb[0] = 32'hFFFFFFFF; xp[0] = 64'hFFFFFFFE00000001;
        xa[1] = 32'h0;        xb[1] = 32'hFFFFFFFF; xp[1] = 64'h0;
        xa[2] = 32'h80000000; xb[2] = 32'd2;        xp[2] = 64'h100000000;
        for (int i = 0; i < 3; i++) begin
            launch32(xa[i], xb[i]);
            wait_done32(edges, bc);
            tests_run++;
            if (product !== xp[i] || edges !== 33) begin
                fails++; $display("FAIL extremes_%0d got %h after %0d edges expected %h after 33", i, product, edges, xp[i]);
            end
        end
    endtask

    task automatic test_ignored_start;
        int edges, done_count;
        logic busy_broken;
        launch32(32'd3, 32'd5);
        edges = 1; done_count = 0; busy_broken = 1'b0;
        while (edges < 40) begin
            if (edges == 10) begin
                a = 32'd7; b = 32'd7; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (edges <= 32 && !busy) busy_broken = 1'b1;
            if (done) done_count++;
            if (edges == 33) begin
                tests_run++;
                if (product !== 64'd15 || done !== 1'b1) begin
                    fails++; $display("FAIL ignored_start_product got %0d done=%b expected 15 done=1", product, done);
                end
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        tests_run++;
        if (done_count !== 1) begin
            fails++; $display("FAIL ignored_start_done_count got %0d expected 1", done_count);
        end
        tests_run++;
        if (busy_broken !== 1'b0) begin
            fails++; $display("FAIL ignored_start_busy got broken=%b expected 0", busy_broken);
        end
    endtask

    task automatic test_back_to_back;
        int edges, bc;
        launch32(32'd3, 32'd5);
        wait_done32(edges, bc);
        tests_run++;
        if (product !== 64'd15 || done !== 1'b1) begin
            fails++; $display("FAIL b2b_first got %0d done=%b expected 15 done=1", product, done);
        end
        a = 32'd6; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++; $display("FAIL b2b_restart got busy=%b done=%b expected 1 0", busy, done);
        end
        wait_done32(edges, bc);
        tests_run++;
        if (product !== 64'd42 || edges !== 33) begin
            fails++; $display("FAIL b2b_second got %0d after %0d edges expected 42 after 33", product, edges);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int edges, bc;
        logic saw_done;
        launch32(32'hDEADBEEF, 32'h12345678);
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
            fails++; $display("FAIL reset_mid_clear got busy=%b done=%b product=%h expected 0", busy, done, product);
        end
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done !== 1'b0) begin
            fails++; $display("FAIL reset_mid_activity got %b expected 0", saw_done);
        end
        rst_n = 1'b1;
        a = 32'd2; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL reset_mid_first_edge got busy=%b expected 1", busy);
        end
        wait_done32(edges, bc);
        tests_run++;
        if (product !== 64'd18 || edges !== 33) begin
            fails++; $display("FAIL reset_mid_rerun got %0d after %0d edges expected 18 after 33", product, edges);
        end
    endtask

    task automatic test_random32;
        logic [31:0] ra, rb;
        logic [63:0] expected;
        int edges, bc;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 50 == 0) ra = 32'hFFFFFFFF;
            expected = 64'(ra) * 64'(rb);
            launch32(ra, rb);
            wait_done32(edges, bc);
            tests_run++;
            if (product !== expected || edges !== 33) begin
                fails++; $display("FAIL random32_%0d a=%h b=%h got %h after %0d edges expected %h after 33", i, ra, rb, product, edges, expected);
            end
        end
    endtask

    task automatic test_random8;
        logic [7:0]  ra, rb;
        logic [15:0] expected;
        int edges;
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
            expected = 16'(ra) * 16'(rb);
            launch8(ra, rb);
            wait_done8(edges);
            tests_run++;
            if (product8 !== expected || edges !== 9) begin
                fails++; $display("FAIL random8_%0d a=%h b=%h got %h after %0d edges expected %h after 9", i, ra, rb, product8, edges, expected);
            end
        end
    endtask

    initial begin
        tests_run = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random32();
        test_random8();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/seq_mul_unit.md
SEQ_MUL_UNIT -- requirements
Module: seq_mul_unit

Interface
REQ-001 SHALL have parameter SIZE, default 32, giving the operand width in bits (legal range 2..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply, sampled on the clk rising edge.
REQ-005 SHALL have port a, input, SIZE bits: unsigned multiplicand, sampled only on the accepting edge.
REQ-006 SHALL have port b, input, SIZE bits: unsigned multiplier, sampled only on the accepting edge.
REQ-007 SHALL have port busy, output, 1 bit: high while a multiply is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking that product is valid.
REQ-009 SHALL have port product, output, 2*SIZE bits: unsigned result a*b.

Function
REQ-010 SHALL implement the three states IDLE, RUN and DONE, plus a down-counter of ceil(log2(SIZE+1)) bits.
REQ-011 SHALL accept start only in IDLE or DONE; on the accepting edge it latches a into register A, loads P = {SIZE zeros, b}, loads the counter with SIZE and enters RUN.
REQ-012 SHALL ignore start while in RUN, with no effect on A, P, the counter or the outputs.
REQ-013 SHALL perform one step on each RUN edge when P[0]=1: {c, s} = P[2*SIZE-1:SIZE] + A using a SIZE-bit adder with carry-in 0 and carry-out c, then P <= {c, s, P[SIZE-1:1]}.
REQ-014 SHALL perform one step on each RUN edge when P[0]=0: P <= {1'b0, P[2*SIZE-1:1]}.
REQ-015 SHALL decrement the counter on each RUN step and leave RUN for DONE on the edge that performs the SIZE-th step.
REQ-016 SHALL give a latency of exactly SIZE+1 rising edges from the accepting edge, counted inclusively, to the edge after which done is high.
REQ-017 SHALL hold done high for exactly one cycle while in DONE, then go to IDLE unless start is high, in which case it goes to RUN (back-to-back operation).
REQ-018 SHALL drive busy = 1 exactly while in RUN and 0 in IDLE and DONE.
REQ-019 SHALL drive product directly from P, so product equals a*b from DONE onwards and holds until the next accepting edge.
REQ-020 SHALL leave product undefined for use while busy=1; it may show partial results, and only a product sampled with done=1 or after done is valid.
REQ-021 SHALL keep all arithmetic unsigned, discard no result bits and never allow the adder carry to overflow P.
REQ-022 SHALL change no state when a or b change outside the accepting edge.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force state to IDLE, counter to 0, A to 0, P to 0, busy to 0, done to 0 and product to 0.
REQ-024 SHALL, on reset asserted mid-RUN, abandon the operation with no done pulse; after release the unit is in IDLE and accepts start on the first rising edge with rst_n=1.
REQ-025 SHALL clear done immediately if reset is asserted in the DONE cycle.

Verification
REQ-026 SHALL cover basic: SIZE=32, a=3, b=5, start for 1 cycle -> busy high for 32 cycles, done pulses once on edge 33, product=15.
REQ-027 SHALL cover extremes: a=b=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001; a=0, b=32'hFFFFFFFF -> product=0; a=32'h80000000, b=2 -> product=64'h100000000.
REQ-028 SHALL cover ignored start: start re-asserted with a=7, b=7 at cycle 10 of an a=3, b=5 run -> product=15, exactly one done pulse, busy unbroken.
REQ-029 SHALL cover back-to-back: start held high in the DONE cycle with a=6, b=7 -> first product 15 seen with done, next RUN begins immediately, second product=42 after a further 33 edges.
REQ-030 SHALL cover reset mid-operation: rst_n low at cycle 16 of a run, asynchronously between edges -> busy, done and product go to 0 at once, no done pulse follows, and a new a=2, b=9 run gives 18.
REQ-031 SHALL cover random: 1000 random operand pairs at SIZE=32 plus 200 at SIZE=8, each compared against a*b computed at 2*SIZE width, with the test failing on any mismatch.
